ram_bank_array: RTL and testbench
=================================

# ram_bank_array

Parametrised successor to `ram_bank`: a simple dual-port word memory with one write port and one read port per clock. It adds byte-lane write enables, a write-first bypass for same-address read/write, a configurable read pipeline with a `r_valid` strobe, and a post-reset zero-fill state machine. It sits wherever `ram_bank` does, for example as a scratch/state store behind a datapath controller, with no change to the write/read port semantics.

## Interface
- `ADDR_BIT`, 3: address width.
- `DATA_BIT`, 16: word width. Must be a multiple of 8.
- `MEM_HEIGHT`, 8: number of words. Must satisfy 1 ≤ `MEM_HEIGHT` ≤ 2^`ADDR_BIT`.
- `READ_LAT`, 1: read latency in cycles. Legal values are 1 and 2.
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: global enable. When 0, no read or write is accepted.
- `we`, input, 1: write request.
- `re`, input, 1: read request.
- `addr_w`, input, `ADDR_BIT`: write address.
- `d_w`, input, `DATA_BIT`: write data.
- `be_w`, input, `DATA_BIT/8`: byte-lane write enables. Bit i controls `d_w[8i+7:8i]`.
- `addr_r`, input, `ADDR_BIT`: read address.
- `d_r`, output, `DATA_BIT`: registered read data.
- `r_valid`, output, 1: one-cycle strobe marking new data on `d_r`.
- `busy`, output, 1: high while zero-fill runs. All requests are ignored while high.

## Operation
- FSM states: INIT and RUN.
  - `rst`=1 forces INIT asynchronously, zeroes the fill counter, and sets `d_r`=0, `r_valid`=0, `busy`=1. It also clears all read pipeline stages.
  - INIT: each edge writes 0 to `mem[cnt]` and increments `cnt`. On the edge that clears address `MEM_HEIGHT-1`, the FSM moves to RUN and `busy` drops.
  - RUN persists until `rst` is asserted.
- Write accept: `en & we & ~busy` at a rising edge. Only lanes with `be_w[i]`=1 are updated.
- Read accept: `en & re & ~busy` at a rising edge. The data word is captured into the pipeline.
- Bypass (write-first): if a read and a write are accepted on the same edge with `addr_r == addr_w`, the read returns the merged word. Enabled lanes come from `d_w`; the remaining lanes come from the old contents.
- Out-of-range addresses (≥ `MEM_HEIGHT`):
  - write: dropped.
  - read: accepted and returns 0 with `r_valid`=1.
- `d_r` holds its last value when no read completes. `r_valid` is 0 in every cycle without a completing read.
- `en`=0, or `busy`=1, blocks both ports. `we`/`re` have no effect and nothing enters the pipeline.
- Reset mid-operation: in-flight reads are discarded (no `r_valid`), memory is re-zeroed, and written data is lost.

## Timing
- Zero-fill length: after `rst` deasserts, `busy` stays high for exactly `MEM_HEIGHT` rising edges. The first request is accepted on edge `MEM_HEIGHT+1`.
- Read latency:
  - `READ_LAT`=1: request at edge N gives `d_r`/`r_valid` updated at edge N (visible in cycle N+1).
  - `READ_LAT`=2: one extra register stage, so the result is visible in cycle N+2.
- Throughput: one read and one write per cycle, fully pipelined, no stalls after INIT.
- A write accepted at edge N is visible to any read accepted at edge ≥ N, via the bypass at N.
- `rst` assertion clears `d_r` and `r_valid` immediately, without waiting for a clock edge.

## Test plan
All scenarios use default parameters unless stated.

- **Reset and zero-fill.** Pulse `rst`, hold `en`=`we`=`re`=1 with `d_w`=0xFFFF during fill.
  - `busy`=1 for exactly 8 edges and no write lands.
  - Then read addresses 0..7: each returns 0x0000 with `r_valid`=1.
- **Sequential write/readback.** After fill, write addr i with data i, `be_w`=2'b11, for i=0..7 on consecutive cycles.
  - Read 0..7 back-to-back: `d_r`=0..7 on consecutive cycles, `r_valid` held high.
  - Repeat with `en`=0: no change, `r_valid`=0.
- **Byte enables.** Write 0xABCD to addr 3 with `be_w`=11, then 0x1200 with `be_w`=10.
  - Reading addr 3 returns 0x12CD.
- **Bypass.** In one cycle, write 0x5555 to addr 5 with `be_w`=01 (old value 0x0005) and read addr 5.
  - `d_r`=0x0055 next cycle.
  - A read of addr 5 the following cycle also returns 0x0055.
- **READ_LAT=2.** Reads of addr 0..3 issued in cycles N..N+3.
  - `r_valid` is high in cycles N+2..N+5 with the matching data.
  - Reads with `MEM_HEIGHT`=6 and addr 7: `d_r`=0, `r_valid`=1.
- **Reset mid-stream.** Write 0x00FF to addr 2, issue a read of addr 2, and assert `rst` before the result appears.
  - `r_valid` never pulses and `busy` rises.
  - After refill, reading addr 2 returns 0x0000.

Source files
------------

// File: rtl/ram_bank_array.sv
// Simple dual-port word memory: byte-lane writes, write-first bypass, a 1- or 2-stage
// registered read path, and a zero-fill sequence that runs after every reset.
module ram_bank_array #(
  parameter int ADDR_BIT   = 3,
  parameter int DATA_BIT   = 16,
  parameter int MEM_HEIGHT = 8,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BIT-1:0]   addr_w,
  input  logic [DATA_BIT-1:0]   d_w,
  input  logic [DATA_BIT/8-1:0] be_w,
  input  logic [ADDR_BIT-1:0]   addr_r,
  output logic [DATA_BIT-1:0]   d_r,
  output logic                  r_valid,
  output logic                  busy
);

  localparam int LANES = DATA_BIT / 8;
  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(MEM_HEIGHT - 1);
  localparam logic [ADDR_BIT:0]   MEM_TOP   = (ADDR_BIT + 1)'(MEM_HEIGHT);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q;
  logic [ADDR_BIT-1:0]   cnt_q;
  logic                  busy_q;

  logic [DATA_BIT-1:0]   mem_q [MEM_HEIGHT];

  logic                  s1_vld_q;
  logic [DATA_BIT-1:0]   s1_dat_q;
  logic                  r_valid_q;
  logic [DATA_BIT-1:0]   d_r_q;

  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  bypass_s;
  logic [DATA_BIT-1:0]   rd_word_d;
  logic                  out_vld_s;
  logic [DATA_BIT-1:0]   out_dat_s;

  function automatic logic [DATA_BIT-1:0] merge_bytes(
    input logic [DATA_BIT-1:0] old_word,
    input logic [DATA_BIT-1:0] new_word,
    input logic [LANES-1:0]    lanes
  );
    logic [DATA_BIT-1:0] res;
    res = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (lanes[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign wr_acc_s      = en & we & ~busy_q;
  assign rd_acc_s      = en & re & ~busy_q;
  assign wr_in_range_s = ({1'b0, addr_w} < MEM_TOP);
  assign rd_in_range_s = ({1'b0, addr_r} < MEM_TOP);
  assign bypass_s      = wr_acc_s & wr_in_range_s & (addr_w == addr_r);

  // Zero-fill sequencer; busy is the registered image of the INIT state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + ADDR_BIT'(1);
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Storage array; not reset, the fill sequence clears it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy_q) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_acc_s && wr_in_range_s) begin
        mem_q[addr_w] <= merge_bytes(mem_q[addr_w], d_w, be_w);
      end
    end
  end

  // Read word selection, including the write-first merge and out-of-range zero.
  always_comb begin
    rd_word_d = '0;
    if (rd_in_range_s) begin
      if (bypass_s) begin
        rd_word_d = merge_bytes(mem_q[addr_r], d_w, be_w);
      end else begin
        rd_word_d = mem_q[addr_r];
      end
    end else begin
      rd_word_d = '0;
    end
  end

  assign out_vld_s = (READ_LAT == 2) ? s1_vld_q : rd_acc_s;
  assign out_dat_s = (READ_LAT == 2) ? s1_dat_q : rd_word_d;

  // Read pipeline and registered outputs; d_r holds when nothing completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      r_valid_q <= 1'b0;
      d_r_q     <= '0;
    end else begin
      s1_vld_q  <= rd_acc_s;
      if (rd_acc_s) begin
        s1_dat_q <= rd_word_d;
      end
      r_valid_q <= out_vld_s;
      if (out_vld_s) begin
        d_r_q <= out_dat_s;
      end
    end
  end

  assign d_r     = d_r_q;
  assign r_valid = r_valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ram_bank_array.sv
// Two instances (default, and READ_LAT=2/MEM_HEIGHT=6) driven with the same stimulus
// and compared each cycle against a word-array model, plus directed literal checks.
module tb_ram_bank_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, we = 1'b0, re = 1'b0;
  logic [2:0]  addr_w = 3'd0, addr_r = 3'd0;
  logic [15:0] d_w = 16'h0000;
  logic [1:0]  be_w = 2'b00;
  logic [15:0] d_r0, d_r1;
  logic        rv0, rv1, busy0, busy1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_bank_array #(.ADDR_BIT(3), .DATA_BIT(16), .MEM_HEIGHT(8), .READ_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .re(re), .addr_w(addr_w), .d_w(d_w),
    .be_w(be_w), .addr_r(addr_r), .d_r(d_r0), .r_valid(rv0), .busy(busy0));

  ram_bank_array #(.ADDR_BIT(3), .DATA_BIT(16), .MEM_HEIGHT(6), .READ_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .re(re), .addr_w(addr_w), .d_w(d_w),
    .be_w(be_w), .addr_r(addr_r), .d_r(d_r1), .r_valid(rv1), .busy(busy1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          h_tab [2] = '{8, 6};
  int          l_tab [2] = '{1, 2};
  logic [15:0] m_mem [2][8];
  int          m_fill [2];
  logic        slot_vld [2][4];
  logic [15:0] slot_dat [2][4];
  logic [15:0] e_dr [2];
  logic        e_rv [2];
  logic        e_busy [2];
  int          edge_no = 0;

  task automatic model_step();
    logic [15:0] mask;
    logic [15:0] rd;
    int due;
    int now;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_fill[i] = h_tab[i];
        e_dr[i]   = 16'h0000;
        e_rv[i]   = 1'b0;
        e_busy[i] = 1'b1;
        for (int s = 0; s < 4; s++) slot_vld[i][s] = 1'b0;
      end
    end else begin
      edge_no++;
      mask = {{8{be_w[1]}}, {8{be_w[0]}}};
      for (int i = 0; i < 2; i++) begin
        if (m_fill[i] > 0) begin
          m_mem[i][h_tab[i] - m_fill[i]] = 16'h0000;
          m_fill[i]--;
        end else begin
          if (en && re) begin
            if (int'(addr_r) >= h_tab[i]) rd = 16'h0000;
            else if (we && addr_w == addr_r) rd = (m_mem[i][addr_r] & ~mask) | (d_w & mask);
            else rd = m_mem[i][addr_r];
            due = (edge_no + l_tab[i] - 1) % 4;
            slot_vld[i][due] = 1'b1;
            slot_dat[i][due] = rd;
          end
          if (en && we && int'(addr_w) < h_tab[i])
            m_mem[i][addr_w] = (m_mem[i][addr_w] & ~mask) | (d_w & mask);
        end
        now = edge_no % 4;
        e_rv[i] = slot_vld[i][now];
        if (slot_vld[i][now]) e_dr[i] = slot_dat[i][now];
        slot_vld[i][now] = 1'b0;
        e_busy[i] = (m_fill[i] > 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_fill[i] = h_tab[i];
      e_dr[i] = 16'h0000; e_rv[i] = 1'b0; e_busy[i] = 1'b1;
      for (int a = 0; a < 8; a++) m_mem[i][a] = 16'h0000;
      for (int s = 0; s < 4; s++) begin slot_vld[i][s] = 1'b0; slot_dat[i][s] = 16'h0000; end
    end
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("dut0 d_r",     {16'h0, d_r0},  {16'h0, e_dr[0]});
      check("dut0 r_valid", {31'h0, rv0},   {31'h0, e_rv[0]});
      check("dut0 busy",    {31'h0, busy0}, {31'h0, e_busy[0]});
      check("dut1 d_r",     {16'h0, d_r1},  {16'h0, e_dr[1]});
      check("dut1 r_valid", {31'h0, rv1},   {31'h0, e_rv[1]});
      check("dut1 busy",    {31'h0, busy1}, {31'h0, e_busy[1]});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus and literal checks ----------------
  initial begin
    int n;
    en = 1'b1; we = 1'b1; re = 1'b1; d_w = 16'hFFFF; be_w = 2'b11;
    step(); step();
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 20) begin step(); n++; end
    we = 1'b0;
    check("fill_length", n, 8);

    for (int i = 0; i < 8; i++) begin
      addr_r = 3'(i); re = 1'b1; step();
      check("fill_read_zero", {16'h0, d_r0}, 32'h0);
      check("fill_read_valid", {31'h0, rv0}, 32'h1);
    end

    re = 1'b0; we = 1'b1; be_w = 2'b11;
    for (int i = 0; i < 8; i++) begin
      addr_w = 3'(i); d_w = 16'(i); step();
    end
    we = 1'b0; re = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr_r = 3'(i); step();
      check("seq_read_data", {16'h0, d_r0}, i);
      check("seq_read_valid", {31'h0, rv0}, 32'h1);
    end

    en = 1'b0; we = 1'b1; d_w = 16'hDEAD;
    for (int i = 0; i < 8; i++) begin
      addr_w = 3'(i); addr_r = 3'(i); step();
      check("disabled_valid", {31'h0, rv0}, 32'h0);
      check("disabled_hold", {16'h0, d_r0}, 32'h7);
    end
    en = 1'b1; we = 1'b0; addr_r = 3'd4; step();
    check("disabled_write_dropped", {16'h0, d_r0}, 32'h4);

    re = 1'b0; we = 1'b1; addr_w = 3'd3; d_w = 16'hABCD; be_w = 2'b11; step();
    d_w = 16'h1200; be_w = 2'b10; step();
    we = 1'b0; re = 1'b1; addr_r = 3'd3; step();
    check("byte_enable", {16'h0, d_r0}, 32'h12CD);

    we = 1'b1; addr_w = 3'd5; d_w = 16'h5555; be_w = 2'b01; addr_r = 3'd5; re = 1'b1; step();
    check("bypass_same_cycle", {16'h0, d_r0}, 32'h0055);
    we = 1'b0; be_w = 2'b11; step();
    check("bypass_followup", {16'h0, d_r0}, 32'h0055);

    re = 1'b0; step(); step();
    re = 1'b1; addr_r = 3'd0; step();
    check("lat2_not_yet", {31'h0, rv1}, 32'h0);
    addr_r = 3'd1; step();
    check("lat2_valid0", {31'h0, rv1}, 32'h1);
    check("lat2_data0", {16'h0, d_r1}, 32'h0);
    addr_r = 3'd2; step();
    check("lat2_data1", {16'h0, d_r1}, 32'h1);
    addr_r = 3'd3; step();
    check("lat2_data2", {16'h0, d_r1}, 32'h2);
    re = 1'b0; step();
    check("lat2_data3", {16'h0, d_r1}, 32'h12CD);
    step();
    check("lat2_idle", {31'h0, rv1}, 32'h0);
    re = 1'b1; addr_r = 3'd7; step();
    check("dut0_addr7", {16'h0, d_r0}, 32'h7);
    re = 1'b0; step();
    check("oor_read_zero", {16'h0, d_r1}, 32'h0);
    check("oor_read_valid", {31'h0, rv1}, 32'h1);

    we = 1'b1; addr_w = 3'd2; d_w = 16'h00FF; be_w = 2'b11; step();
    we = 1'b0; re = 1'b1; addr_r = 3'd2; step();
    re = 1'b0; #1 rst = 1'b1; #1;
    check("midrst_busy0", {31'h0, busy0}, 32'h1);
    check("midrst_busy1", {31'h0, busy1}, 32'h1);
    check("midrst_no_valid", {31'h0, rv1}, 32'h0);
    check("midrst_dr_clear", {16'h0, d_r0}, 32'h0);
    step();
    check("midrst_no_valid_late", {31'h0, rv1}, 32'h0);
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 20) begin step(); n++; end
    check("refill_length", n, 8);
    re = 1'b1; addr_r = 3'd2; step();
    check("refill_data0", {16'h0, d_r0}, 32'h0);
    re = 1'b0; step();
    check("refill_data1", {16'h0, d_r1}, 32'h0);
    check("refill_valid1", {31'h0, rv1}, 32'h1);

    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      en     = ($urandom_range(0, 7) != 0);
      we     = 1'($urandom_range(0, 1));
      re     = 1'($urandom_range(0, 1));
      addr_w = 3'($urandom_range(0, 7));
      addr_r = ($urandom_range(0, 3) == 0) ? addr_w : 3'($urandom_range(0, 7));
      d_w    = 16'($urandom);
      be_w   = 2'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; en = 1'b0;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
